// File: rtl/two_wheel_platform_if.sv
// Pin bundle between the chassis controller and the outside world:
// host UART line, H-bridge drive pins and wheel-encoder inputs.
interface two_wheel_platform_if;
  logic       RX;
  logic       TX;
  logic [1:0] Mta;
  logic       ENa;
  logic [1:0] Mtb;
  logic       ENb;
  logic [1:0] Evnt;

  modport slave  (input RX, Evnt, output TX, Mta, ENa, Mtb, ENb);
  modport master (output RX, Evnt, input TX, Mta, ENa, Mtb, ENb);
endinterface

// File: rtl/two_wheel_platform.sv
// UART-commanded two-wheel chassis controller: 8N1 command parser, shared-counter
// PWM for both H-bridges, saturating encoder edge counters reported over TX.
//
// state    | meaning
// R_IDLE   | RX line idle, waiting for a falling edge
// R_START  | half-bit wait, start bit re-check (glitch filter)
// R_DATA   | shifting in 8 data bits, LSB first
// R_STOP   | sampling stop bit
// R_WAIT   | framing error, waiting for RX high before re-arming
// P_IDLE   | parser waiting for a command byte
// P_ARG    | parser waiting for the argument of cmd_q
module two_wheel_platform #(
  parameter string VENDOR   = "Simulation",
  parameter int    MEM_SIZE = 16384,
  parameter int    BAUD_DIV = 768
) (
  input  logic Clk,
  input  logic sys_rst,
  two_wheel_platform_if.slave pins
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_st_t;
  typedef enum logic {P_IDLE, P_ARG} p_st_t;

  logic cfg_unused;
  assign cfg_unused = (MEM_SIZE > 0) && (VENDOR != "");

  logic [1:0]    rx_sync_q;
  logic          rx_prev_q;
  rx_st_t        rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_valid_q, rx_valid_d;

  p_st_t      p_st_q, p_st_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] duty_a_q, duty_a_d, duty_b_q, duty_b_d;
  logic [1:0] dir_a_q, dir_a_d, dir_b_q, dir_b_d;
  logic [1:0] mta_q, mtb_q;
  logic       push, clr;

  logic [7:0] pwm_q;
  logic       en_a_q, en_b_q;

  logic [1:0] ev_s1_q, ev_s2_q, ev_s3_q, rise;
  logic [7:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

  logic [7:0]    q0_q, q0_d, q1_q, q1_d;
  logic [1:0]    q_cnt_q, q_cnt_d;
  logic          tx_busy_q, tx_busy_d;
  logic [9:0]    tx_sh_q, tx_sh_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          tx_done, load;

  logic rx_s, rx_fall;
  assign rx_s    = rx_sync_q[1];
  assign rx_fall = rx_prev_q & ~rx_s;

  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_valid_d = 1'b0;
    case (rx_st_q)
      R_IDLE: if (rx_fall) begin
        rx_st_d  = R_START;
        rx_cnt_d = HALF;
      end
      R_START: if (rx_cnt_q == '0) begin
        if (rx_s) rx_st_d = R_IDLE;
        else begin
          rx_st_d  = R_DATA;
          rx_cnt_d = FULL;
          rx_bit_d = 3'd0;
        end
      end else rx_cnt_d = rx_cnt_q - 1'b1;
      R_DATA: if (rx_cnt_q == '0) begin
        rx_sh_d  = {rx_s, rx_sh_q[7:1]};
        rx_cnt_d = FULL;
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_st_d = R_STOP;
      end else rx_cnt_d = rx_cnt_q - 1'b1;
      R_STOP: if (rx_cnt_q == '0) begin
        if (rx_s) begin
          rx_valid_d = 1'b1;
          rx_st_d    = R_IDLE;
        end else rx_st_d = R_WAIT;
      end else rx_cnt_d = rx_cnt_q - 1'b1;
      R_WAIT: if (rx_s) rx_st_d = R_IDLE;
      default: rx_st_d = R_IDLE;
    endcase
  end

  always_comb begin
    p_st_d   = p_st_q;
    cmd_d    = cmd_q;
    duty_a_d = duty_a_q;
    duty_b_d = duty_b_q;
    dir_a_d  = dir_a_q;
    dir_b_d  = dir_b_q;
    push     = 1'b0;
    clr      = 1'b0;
    if (rx_valid_q) begin
      if (p_st_q == P_ARG) begin
        p_st_d = P_IDLE;
        case (cmd_q)
          8'h41:   duty_a_d = rx_sh_q;
          8'h42:   duty_b_d = rx_sh_q;
          8'h44: begin
            dir_a_d = rx_sh_q[1:0];
            dir_b_d = rx_sh_q[3:2];
          end
          default: ;
        endcase
      end else begin
        case (rx_sh_q)
          8'h41, 8'h42, 8'h44: begin
            p_st_d = P_ARG;
            cmd_d  = rx_sh_q;
          end
          8'h53: begin
            duty_a_d = 8'd0;
            duty_b_d = 8'd0;
            dir_a_d  = 2'b00;
            dir_b_d  = 2'b00;
          end
          // a pending response blocks a new report so counts are never lost
          8'h45: if (q_cnt_q == 2'd0) begin
            push = 1'b1;
            clr  = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign rise = ev_s2_q & ~ev_s3_q;

  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (clr) begin
      cnt_a_d = {7'd0, rise[0]};
      cnt_b_d = {7'd0, rise[1]};
    end else begin
      if (rise[0] && cnt_a_q != 8'hFF) cnt_a_d = cnt_a_q + 8'd1;
      if (rise[1] && cnt_b_q != 8'hFF) cnt_b_d = cnt_b_q + 8'd1;
    end
  end

  assign tx_done = tx_busy_q && (tx_cnt_q == '0) && (tx_bit_q == 4'd9);
  assign load    = (q_cnt_q != 2'd0) && (!tx_busy_q || tx_done);

  always_comb begin
    q0_d      = q0_q;
    q1_d      = q1_q;
    q_cnt_d   = q_cnt_q;
    tx_busy_d = tx_busy_q;
    tx_sh_d   = tx_sh_q;
    tx_bit_d  = tx_bit_q;
    tx_cnt_d  = tx_cnt_q;
    if (push) begin
      q0_d    = cnt_a_q;
      q1_d    = cnt_b_q;
      q_cnt_d = 2'd2;
    end
    if (load) begin
      tx_sh_d   = {1'b1, q0_q, 1'b0};
      tx_busy_d = 1'b1;
      tx_bit_d  = 4'd0;
      tx_cnt_d  = FULL;
      q0_d      = q1_q;
      q_cnt_d   = q_cnt_q - 2'd1;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == '0) begin
        if (tx_bit_q == 4'd9) tx_busy_d = 1'b0;
        else begin
          tx_sh_d  = {1'b1, tx_sh_q[9:1]};
          tx_bit_d = tx_bit_q + 4'd1;
          tx_cnt_d = FULL;
        end
      end else tx_cnt_d = tx_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (sys_rst) begin
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'd0;
      rx_valid_q <= 1'b0;
      p_st_q     <= P_IDLE;
      cmd_q      <= 8'd0;
      duty_a_q   <= 8'd0;
      duty_b_q   <= 8'd0;
      dir_a_q    <= 2'b00;
      dir_b_q    <= 2'b00;
      mta_q      <= 2'b00;
      mtb_q      <= 2'b00;
      pwm_q      <= 8'd0;
      en_a_q     <= 1'b0;
      en_b_q     <= 1'b0;
      ev_s1_q    <= 2'b00;
      ev_s2_q    <= 2'b00;
      ev_s3_q    <= 2'b00;
      cnt_a_q    <= 8'd0;
      cnt_b_q    <= 8'd0;
      q0_q       <= 8'd0;
      q1_q       <= 8'd0;
      q_cnt_q    <= 2'd0;
      tx_busy_q  <= 1'b0;
      tx_sh_q    <= 10'h3FF;
      tx_bit_q   <= 4'd0;
      tx_cnt_q   <= '0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], pins.RX};
      rx_prev_q  <= rx_s;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_valid_q <= rx_valid_d;
      p_st_q     <= p_st_d;
      cmd_q      <= cmd_d;
      duty_a_q   <= duty_a_d;
      duty_b_q   <= duty_b_d;
      dir_a_q    <= dir_a_d;
      dir_b_q    <= dir_b_d;
      mta_q      <= dir_a_q;
      mtb_q      <= dir_b_q;
      pwm_q      <= pwm_q + 8'd1;
      en_a_q     <= pwm_q < duty_a_q;
      en_b_q     <= pwm_q < duty_b_q;
      ev_s1_q    <= pins.Evnt;
      ev_s2_q    <= ev_s1_q;
      ev_s3_q    <= ev_s2_q;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      q0_q       <= q0_d;
      q1_q       <= q1_d;
      q_cnt_q    <= q_cnt_d;
      tx_busy_q  <= tx_busy_d;
      tx_sh_q    <= tx_sh_d;
      tx_bit_q   <= tx_bit_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  assign pins.TX  = tx_busy_q ? tx_sh_q[0] : 1'b1;
  assign pins.Mta = mta_q;
  assign pins.Mtb = mtb_q;
  assign pins.ENa = en_a_q;
  assign pins.ENb = en_b_q;
endmodule

// File: tb/tb_two_wheel_platform.sv
// Bench for two_wheel_platform: drives UART commands and encoder pulses,
// decodes TX frames against a queue of expected report bytes.
module tb_two_wheel_platform;
  localparam int BAUD = 16;

  logic Clk = 1'b0;
  logic sys_rst;
  always #5 Clk = ~Clk;

  two_wheel_platform_if pins();

  two_wheel_platform #(
    .VENDOR("Simulation"),
    .MEM_SIZE(16384),
    .BAUD_DIV(BAUD)
  ) dut (
    .Clk(Clk),
    .sys_rst(sys_rst),
    .pins(pins)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];
  longint tx_start[$];
  int rx_bytes = 0;
  bit mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    @(negedge Clk);
    pins.RX = 1'b0;
    repeat (BAUD) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      pins.RX = b[i];
      repeat (BAUD) @(negedge Clk);
    end
    pins.RX = good_stop;
    repeat (BAUD) @(negedge Clk);
    if (!good_stop) begin
      repeat (BAUD) @(negedge Clk);
      pins.RX = 1'b1;
      repeat (2 * BAUD) @(negedge Clk);
    end
    pins.RX = 1'b1;
    repeat (4) @(negedge Clk);
  endtask

  task automatic meas(output int ha, output int hb);
    ha = 0;
    hb = 0;
    repeat (256) begin
      @(negedge Clk);
      ha += int'(pins.ENa);
      hb += int'(pins.ENb);
    end
  endtask

  task automatic pulses(input int na, input int nb);
    int n;
    n = (na > nb) ? na : nb;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      pins.Evnt = {logic'(i < nb), logic'(i < na)};
      repeat (3) @(negedge Clk);
      pins.Evnt = 2'b00;
      repeat (3) @(negedge Clk);
    end
    repeat (6) @(negedge Clk);
  endtask

  task automatic wait_bytes(input int n);
    int budget;
    budget = 30 * BAUD * 10;
    while (rx_bytes < n && budget > 0) begin
      @(posedge Clk);
      budget--;
    end
    check("tx_resp_count", rx_bytes, n);
  endtask

  task automatic report(input logic [7:0] ea, input logic [7:0] eb, input int total);
    exp_q.push_back(ea);
    exp_q.push_back(eb);
    send_byte(8'h45, 1'b1);
    wait_bytes(total);
    if (tx_start.size() >= 2)
      check("tx_back_to_back", 32'((tx_start[tx_start.size()-1] - tx_start[tx_start.size()-2]) / 10), 10 * BAUD);
  endtask

  // TX frame decoder feeding the scoreboard
  initial begin
    logic [7:0] b;
    longint st;
    wait (mon_en);
    forever begin
      @(negedge pins.TX);
      st = $time;
      repeat (BAUD / 2) @(posedge Clk);
      @(negedge Clk);
      check("tx_start_bit", pins.TX, 0);
      for (int i = 0; i < 8; i++) begin
        repeat (BAUD) @(posedge Clk);
        @(negedge Clk);
        b[i] = pins.TX;
      end
      repeat (BAUD) @(posedge Clk);
      @(negedge Clk);
      check("tx_stop_bit", pins.TX, 1);
      tx_start.push_back(st);
      check("tx_sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("tx_byte", b, exp_q.pop_front());
      rx_bytes++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ha, hb;
    bit low;
    sys_rst   = 1'b1;
    pins.RX   = 1'b1;
    pins.Evnt = 2'b00;
    repeat (5) @(negedge Clk);
    sys_rst = 1'b0;
    mon_en  = 1'b1;
    check("rst_tx", pins.TX, 1);
    check("rst_ena", pins.ENa, 0);
    check("rst_enb", pins.ENb, 0);
    check("rst_mta", pins.Mta, 0);
    check("rst_mtb", pins.Mtb, 0);

    low = 1'b0;
    repeat (10 * BAUD) begin
      @(negedge Clk);
      if (pins.TX !== 1'b1 || pins.ENa !== 1'b0 || pins.ENb !== 1'b0) low = 1'b1;
    end
    check("idle_quiet", low, 0);

    send_byte(8'h44, 1'b1);
    send_byte(8'h09, 1'b1);
    check("dir_mta", pins.Mta, 2'b01);
    check("dir_mtb", pins.Mtb, 2'b10);

    send_byte(8'h41, 1'b1);
    send_byte(8'h80, 1'b1);
    meas(ha, hb);
    check("duty_a_128", ha, 128);
    check("duty_b_0", hb, 0);

    send_byte(8'h42, 1'b1);
    send_byte(8'hFF, 1'b1);
    meas(ha, hb);
    check("duty_b_255", hb, 255);

    send_byte(8'h53, 1'b1);
    meas(ha, hb);
    check("stop_a", ha, 0);
    check("stop_b", hb, 0);
    check("stop_mta", pins.Mta, 0);
    check("stop_mtb", pins.Mtb, 0);

    pulses(3, 300);
    report(8'h03, 8'hFF, 2);
    report(8'h00, 8'h00, 4);
    pulses(2, 0);
    report(8'h02, 8'h00, 6);

    send_byte(8'h41, 1'b0);
    send_byte(8'h41, 1'b1);
    send_byte(8'h10, 1'b1);
    meas(ha, hb);
    check("framing_drop_duty_a", ha, 16);

    @(negedge Clk);
    pins.RX = 1'b0;
    repeat (4) @(negedge Clk);
    pins.RX = 1'b1;
    repeat (2 * BAUD) @(negedge Clk);
    send_byte(8'h7E, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h06, 1'b1);
    check("glitch_mta", pins.Mta, 2'b10);
    check("glitch_mtb", pins.Mtb, 2'b01);

    repeat (12 * BAUD) @(negedge Clk);
    check("tx_total_bytes", rx_bytes, 6);
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
